// File: rtl/msrv32_muldiv.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider
// working on operand magnitudes, with a single-cycle fast path for divide-by-zero and signed overflow.
module msrv32_muldiv (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] op_1_in,
   input  logic [31:0] op_2_in,
   input  logic        kill_in,
   output logic        busy_out,
   output logic        done_out,
   output logic [31:0] result_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] opb_q;
   logic [2:0]  f3_q;
   logic        neg_q;
   logic        neg_rem_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] result_q;

   logic        sgn_1_s;
   logic        sgn_2_s;
   logic [31:0] mag_1_s;
   logic [31:0] mag_2_s;
   logic        fast_s;
   logic [31:0] fast_res_s;
   logic [32:0] sum_s;
   logic [32:0] diff_s;
   logic [63:0] acc_d;
   logic [63:0] prod_s;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [31:0] res_d;

   // Operand signs, magnitudes and fast-path detection for the request on the inputs
   always_comb begin
      if (funct3_in[2]) begin
         sgn_1_s = ~funct3_in[0] & op_1_in[31];
         sgn_2_s = ~funct3_in[0] & op_2_in[31];
      end else begin
         sgn_1_s = (funct3_in[1:0] != 2'b11) & op_1_in[31];
         sgn_2_s = ~funct3_in[1] & op_2_in[31];
      end
      mag_1_s = sgn_1_s ? (32'd0 - op_1_in) : op_1_in;
      mag_2_s = sgn_2_s ? (32'd0 - op_2_in) : op_2_in;
      if (funct3_in[2] && (op_2_in == 32'd0)) begin
         fast_s     = 1'b1;
         fast_res_s = funct3_in[1] ? op_1_in : 32'hFFFF_FFFF;
      end else if (funct3_in[2] && !funct3_in[0] &&
                   (op_1_in == 32'h8000_0000) && (op_2_in == 32'hFFFF_FFFF)) begin
         fast_s     = 1'b1;
         fast_res_s = funct3_in[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         fast_s     = 1'b0;
         fast_res_s = 32'd0;
      end
   end

   // One iteration step; acc_q holds {high product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
      diff_s = acc_q[63:31] - {1'b0, opb_q};
      if (state_q == S_MUL) begin
         acc_d = {sum_s, acc_q[31:1]};
      end else if (!diff_s[32]) begin
         acc_d = {diff_s[31:0], acc_q[30:0], 1'b1};
      end else begin
         acc_d = {acc_q[62:0], 1'b0};
      end
      prod_s = neg_q ? (64'd0 - acc_d) : acc_d;
      quo_s  = neg_q ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
      rem_s  = neg_rem_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
      if (state_q == S_MUL) begin
         res_d = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
      end else if (f3_q[1]) begin
         res_d = rem_s;
      end else begin
         res_d = quo_s;
      end
   end

   // Control FSM with registered status outputs and datapath registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         acc_q     <= 64'd0;
         opb_q     <= 32'd0;
         f3_q      <= 3'd0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= 32'd0;
      end else if (kill_in) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               cnt_q  <= 5'd0;
               if (start_in) begin
                  f3_q      <= funct3_in;
                  neg_q     <= sgn_1_s ^ sgn_2_s;
                  neg_rem_q <= sgn_1_s;
                  if (funct3_in[2]) begin
                     opb_q <= mag_2_s;
                     acc_q <= {32'd0, mag_1_s};
                  end else begin
                     opb_q <= mag_1_s;
                     acc_q <= {32'd0, mag_2_s};
                  end
                  if (fast_s) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= fast_res_s;
                  end else begin
                     state_q <= funct3_in[2] ? S_DIV : S_MUL;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_MUL, S_DIV: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= res_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_out   = busy_q;
   assign done_out   = done_q;
   assign result_out = result_q;

endmodule

// File: tb/tb_msrv32_muldiv.sv
// Self-checking bench for msrv32_muldiv: timeline/arithmetic reference model checked every cycle,
// directed literal cases, abort cases and a randomized phase.
module tb_msrv32_muldiv;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        start_in = 1'b0;
   logic [2:0]  funct3_in = 3'd0;
   logic [31:0] op_1_in = 32'd0;
   logic [31:0] op_2_in = 32'd0;
   logic        kill_in = 1'b0;
   logic        busy_out;
   logic        done_out;
   logic [31:0] result_out;

   int tests = 0;
   int fails = 0;

   msrv32_muldiv dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .funct3_in(funct3_in),
      .op_1_in(op_1_in), .op_2_in(op_2_in), .kill_in(kill_in),
      .busy_out(busy_out), .done_out(done_out), .result_out(result_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Architectural result of an RV32M operation
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      p  = 64'd0;
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
         3'd6: begin
            if (b == 32'd0) return a;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 32'd0) ? a : (a % b);
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 32'd0) ||
                      (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   // Inputs as seen by the DUT at each rising edge
   logic        s_rst = 1'b1, s_start = 1'b0, s_kill = 1'b0;
   logic [2:0]  s_f3 = 3'd0;
   logic [31:0] s_a = 32'd0, s_b = 32'd0;
   always @(posedge clk_in) begin
      s_rst   <= rst_in;
      s_start <= start_in;
      s_kill  <= kill_in;
      s_f3    <= funct3_in;
      s_a     <= op_1_in;
      s_b     <= op_2_in;
   end

   // Reference model: an in-flight operation finishes 32 edges after acceptance
   bit          chk_en = 1'b0;
   bit          pend = 1'b0;
   longint      cyc = 0;
   longint      due = 0;
   logic [31:0] pend_res = 32'd0;
   logic        e_busy = 1'b0, e_done = 1'b0;
   logic [31:0] e_res = 32'd0;
   int          n_done = 0;

   always @(negedge clk_in) begin
      cyc++;
      if (s_rst) begin
         pend = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_res = 32'd0; chk_en = 1'b1;
      end else if (s_kill) begin
         pend = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end else begin
         e_done = 1'b0;
         if (pend) begin
            if (cyc == due) begin
               pend = 1'b0; e_done = 1'b1; e_res = pend_res;
            end
         end else if (s_start) begin
            if (is_fast(s_f3, s_a, s_b)) begin
               e_done = 1'b1;
               e_res  = ref_result(s_f3, s_a, s_b);
            end else begin
               pend     = 1'b1;
               due      = cyc + 32;
               pend_res = ref_result(s_f3, s_a, s_b);
            end
         end
         e_busy = pend;
      end
      if (chk_en) begin
         chk("busy", {63'd0, busy_out}, {63'd0, e_busy});
         chk("done", {63'd0, done_out}, {63'd0, e_done});
         chk("result", {32'd0, result_out}, {32'd0, e_res});
         if (done_out) n_done++;
      end
   end

   // Issue one request from the current negedge; wait for done with a bound
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat_exp, input string name);
      int lat;
      start_in = 1'b1; funct3_in = f; op_1_in = a; op_2_in = b;
      @(negedge clk_in);
      start_in = 1'b0;
      lat = 1;
      while (!done_out && lat < 40) begin
         op_1_in = $urandom; op_2_in = $urandom; funct3_in = 3'($urandom);
         @(negedge clk_in);
         lat++;
      end
      chk({name, " latency"}, 64'(lat), 64'(lat_exp));
      chk({name, " value"}, {32'd0, result_out}, {32'd0, r});
   endtask

   logic [2:0]  d_f3 [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd7, 3'd4, 3'd6};
   logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_r  [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
   int          d_l  [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

   initial begin
      int sel;
      int done_before;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("reset result", {32'd0, result_out}, 64'd0);
      chk("reset busy", {63'd0, busy_out}, 64'd0);

      // Directed cases; odd entries start back-to-back while the previous op is in DONE
      for (int i = 0; i < 12; i++) begin
         run_op(d_f3[i], d_a[i], d_b[i], d_r[i], d_l[i], $sformatf("op%0d", i));
         if (i % 2 == 1) @(negedge clk_in);
      end

      // Kill on iteration 10 keeps the previous result
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu pre-kill");
      @(negedge clk_in);
      start_in = 1'b1; funct3_in = 3'd0; op_1_in = $urandom; op_2_in = $urandom;
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (9) @(negedge clk_in);
      kill_in = 1'b1;
      @(negedge clk_in);
      kill_in = 1'b0;
      chk("kill busy", {63'd0, busy_out}, 64'd0);
      chk("kill result", {32'd0, result_out}, 64'd14);
      done_before = n_done;
      repeat (40) @(negedge clk_in);
      chk("kill no done", 64'(n_done), 64'(done_before));

      // Reset on iteration 20
      start_in = 1'b1; funct3_in = 3'd4; op_1_in = 32'd1000; op_2_in = 32'd3;
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (19) @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      chk("rst result", {32'd0, result_out}, 64'd0);
      chk("rst busy", {63'd0, busy_out}, 64'd0);

      // Randomized traffic; the reference model checks every cycle
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk_in);
         start_in  = ($urandom_range(0, 3) == 0);
         kill_in   = ($urandom_range(0, 99) == 0);
         rst_in    = ($urandom_range(0, 499) == 0);
         funct3_in = 3'($urandom);
         sel = $urandom_range(0, 7);
         op_1_in = $urandom;
         op_2_in = $urandom;
         if (sel == 0) op_2_in = 32'd0;
         else if (sel == 1) begin op_1_in = 32'h8000_0000; op_2_in = 32'hFFFF_FFFF; end
         else if (sel == 2) begin
            op_1_in = 32'($signed($urandom_range(0, 40)) - 20);
            op_2_in = 32'($signed($urandom_range(0, 16)) - 8);
         end
      end
      start_in = 1'b0; kill_in = 1'b0; rst_in = 1'b0;
      repeat (40) @(negedge clk_in);
      chk("random saw done pulses", 64'(n_done > 20), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
